// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared decode constants, encodings and helpers for the ID stage
package id_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 2;

    typedef enum logic [1:0] {
        ALUOP_ADD = 2'b00,
        ALUOP_BR  = 2'b01,
        ALUOP_R   = 2'b10,
        ALUOP_I   = 2'b11
    } aluop_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_e sel);
        logic [31:0] imm;
        case (sel)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // f7b = {inst[30], inst[25]}; inst[25] marks M-extension ops, which fall back to ADD
    function automatic logic [3:0] alu_decode(input logic [1:0] aluop, input logic [2:0] f3,
                                              input logic [1:0] f7b);
        logic [3:0] op;
        case (aluop)
            ALUOP_ADD: op = ALU_ADD;
            ALUOP_BR:  op = ALU_SUB;
            ALUOP_R:   op = f7b[0] ? ALU_ADD : {f7b[1], f3};
            default:   op = (f3 == 3'b101) ? {f7b[1], f3} : {1'b0, f3};
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - single-edge register file with write-back bypass, x0 reads zero
module regfile_bypass
    import id_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] mem_q [NREG];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-cycle write-back is forwarded so a reader never sees the stale value
    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (raddr1_i != '0) begin
            rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
        end
        if (raddr2_i != '0) begin
            rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - RV32I decode, load-use scoreboard and ID/EX pipeline register
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int LOAD_LAT = 1,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk_50,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    output logic            id_ready,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [XLEN-1:0] ex_imm,
    output logic [AW-1:0]   ex_rs1,
    output logic [AW-1:0]   ex_rs2,
    output logic [AW-1:0]   ex_rd,
    output logic [7:0]      ex_ctrl,
    output logic [3:0]      ex_alu_ctrl
);

    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [AW-1:0] rs1, rs2, rd;
    logic [7:0]    ctrl;
    logic [3:0]    alu;
    imm_e          imm_sel;
    logic          use_rs1, use_rs2, is_load;
    logic [XLEN-1:0] rd1, rd2, imm;

    assign opcode = if_inst[6:0];
    assign funct3 = if_inst[14:12];
    assign rd     = if_inst[7 +: AW];
    assign rs1    = if_inst[15 +: AW];
    assign rs2    = if_inst[20 +: AW];

    always_comb begin
        ctrl    = '0;
        imm_sel = IMM_NONE;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[1:0] = ALUOP_R;
                use_rs2 = 1'b1;
            end
            OP_IALU: begin
                ctrl[CTRL_ALUSRC] = 1'b1;
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[1:0] = ALUOP_I;
                imm_sel = IMM_I;
            end
            OP_LOAD: begin
                ctrl[CTRL_ALUSRC] = 1'b1;
                ctrl[CTRL_MEMTOREG] = 1'b1;
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_MEMREAD] = 1'b1;
                imm_sel = IMM_I;
            end
            OP_STORE: begin
                ctrl[CTRL_ALUSRC] = 1'b1;
                ctrl[CTRL_MEMWRITE] = 1'b1;
                imm_sel = IMM_S;
                use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                ctrl[CTRL_BRANCH] = 1'b1;
                ctrl[1:0] = ALUOP_BR;
                imm_sel = IMM_B;
                use_rs2 = 1'b1;
            end
            OP_JAL: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_BRANCH] = 1'b1;
                imm_sel = IMM_J;
                use_rs1 = 1'b0;
            end
            OP_JALR: begin
                ctrl[CTRL_ALUSRC] = 1'b1;
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_BRANCH] = 1'b1;
                imm_sel = IMM_I;
            end
            OP_LUI, OP_AUIPC: begin
                ctrl[CTRL_ALUSRC] = 1'b1;
                ctrl[CTRL_REGWRITE] = 1'b1;
                imm_sel = IMM_U;
                use_rs1 = 1'b0;
            end
            default: ;
        endcase
    end

    assign is_load = (opcode == OP_LOAD);
    assign alu     = alu_decode(ctrl[1:0], funct3, {if_inst[30], if_inst[25]});
    assign imm     = XLEN'($signed(imm_gen(if_inst, imm_sel)));

    regfile_bypass #(.NREG(NREG), .XLEN(XLEN)) u_rf (
        .clk_i    (clk_50),
        .rst_i    (rst),
        .we_i     (wb_we),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    // Entry 0 tracks the instruction in ID/EX; older loads age toward LOAD_LAT-1
    logic [LOAD_LAT-1:0]         sb_v_q, sb_v_d;
    logic [LOAD_LAT-1:0][AW-1:0] sb_rd_q, sb_rd_d;
    logic hazard, adv, issue;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (sb_v_q[i] && ((use_rs1 && sb_rd_q[i] == rs1) || (use_rs2 && sb_rd_q[i] == rs2))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & if_valid;
    end

    assign adv      = ex_ready | flush;
    assign issue    = if_valid & ~flush & ex_ready & ~hazard;
    assign id_ready = flush | (ex_ready & ~hazard);

    always_comb begin
        sb_v_d  = sb_v_q;
        sb_rd_d = sb_rd_q;
        if (adv) begin
            for (int i = LOAD_LAT - 1; i > 0; i--) begin
                sb_v_d[i]  = sb_v_q[i-1];
                sb_rd_d[i] = sb_rd_q[i-1];
            end
            sb_v_d[0]  = issue & is_load & (rd != '0);
            sb_rd_d[0] = rd;
        end
    end

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_rd1_q, ex_rd1_d, ex_rd2_q, ex_rd2_d, ex_imm_q, ex_imm_d;
    logic [AW-1:0]   ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
    logic [7:0]      ex_ctrl_q, ex_ctrl_d;
    logic [3:0]      ex_alu_q, ex_alu_d;

    always_comb begin
        ex_valid_d = 1'b0;
        ex_rd1_d   = '0;
        ex_rd2_d   = '0;
        ex_imm_d   = '0;
        ex_rs1_d   = '0;
        ex_rs2_d   = '0;
        ex_rd_d    = '0;
        ex_ctrl_d  = '0;
        ex_alu_d   = '0;
        if (issue) begin
            ex_valid_d = 1'b1;
            ex_rd1_d   = rd1;
            ex_rd2_d   = rd2;
            ex_imm_d   = imm;
            ex_rs1_d   = rs1;
            ex_rs2_d   = rs2;
            ex_rd_d    = rd;
            ex_ctrl_d  = ctrl;
            ex_alu_d   = alu;
        end
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            sb_v_q     <= '0;
            sb_rd_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            ex_ctrl_q  <= '0;
            ex_alu_q   <= '0;
        end else begin
            sb_v_q  <= sb_v_d;
            sb_rd_q <= sb_rd_d;
            if (adv) begin
                ex_valid_q <= ex_valid_d;
                ex_rd1_q   <= ex_rd1_d;
                ex_rd2_q   <= ex_rd2_d;
                ex_imm_q   <= ex_imm_d;
                ex_rs1_q   <= ex_rs1_d;
                ex_rs2_q   <= ex_rs2_d;
                ex_rd_q    <= ex_rd_d;
                ex_ctrl_q  <= ex_ctrl_d;
                ex_alu_q   <= ex_alu_d;
            end
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_rd1      = ex_rd1_q;
    assign ex_rd2      = ex_rd2_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rs1      = ex_rs1_q;
    assign ex_rs2      = ex_rs2_q;
    assign ex_rd       = ex_rd_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign ex_alu_ctrl = ex_alu_q;

endmodule
